// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl
// Sequencer for the UART loopback path: receiver -> FIR -> transmitter.
// Each received byte goes to the FIR with a one-cycle strobe. After a fixed
// pipeline latency the FIR result is captured into a small circular FIFO.
// The FIFO is then drained into the transmitter one byte per tx_done.
// In bypass mode the raw byte is queued and the FIR is skipped.
// Lost bytes are counted in a saturating 8-bit counter.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   rx_dv/rx_byte : received byte, rx_dv is a one-cycle pulse
//   bypass        : queue the raw byte instead of the FIR result (sampled in IN_IDLE)
//   fir_data_in   : byte presented to the FIR
//   fir_strobe    : one-cycle FIR input valid
//   fir_data_out  : FIR result, valid FIR_LATENCY cycles after fir_strobe
//   tx_dv/tx_byte : one-cycle transmit request; tx_byte is held until the next request
//   tx_done       : one-cycle pulse when the transmitter has finished
//   fifo_count    : FIFO occupancy, 0..FIFO_DEPTH
//   drop_cnt      : saturating count of discarded bytes
//   busy          : any FSM is active or the FIFO holds data
//
// Handshake: a byte is accepted only when rx_dv=1 in IN_IDLE. rx_dv in any
// other state is a drop. Each tx_dv pulse is one transmit request.
// No further request is issued until tx_done has been seen in TX_WAIT.
module fir_stream_ctrl #(
  parameter int FIR_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              bypass,
  output logic [7:0]        fir_data_in,
  output logic              fir_strobe,
  input  logic [7:0]        fir_data_out,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_done,
  output logic [ADDR_W:0]   fifo_count,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {IN_IDLE, FEED, WAIT, CAPTURE} in_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} out_state_e;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [3:0]        LAT      = 4'(FIR_LATENCY);

  in_state_e         in_state_q, in_state_d;
  out_state_e        out_state_q, out_state_d;
  logic [7:0]        fir_data_in_q, fir_data_in_d;
  logic [7:0]        raw_q, raw_d;          // latched raw byte for bypass captures
  logic              raw_sel_q, raw_sel_d;  // current capture comes from raw_q
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic       push_req, full, push, pop;
  logic [7:0] capture_val;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  always_comb begin
    push_req    = (in_state_q == CAPTURE);
    full        = (count_q == FULL_CNT);
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    push        = push_req && !full;
    pop         = (out_state_q == TX_REQ);
    capture_val = raw_sel_q ? raw_q : fir_data_out;
    drop_inc    = {1'b0, (rx_dv && (in_state_q != IN_IDLE))} + {1'b0, (push_req && full)};
    drop_sum    = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
  end

  // Input FSM
  always_comb begin
    in_state_d    = in_state_q;
    fir_data_in_d = fir_data_in_q;
    raw_d         = raw_q;
    raw_sel_d     = raw_sel_q;
    wait_cnt_d    = wait_cnt_q;
    case (in_state_q)
      IN_IDLE: begin
        if (rx_dv) begin
          if (bypass) begin
            raw_d      = rx_byte;
            raw_sel_d  = 1'b1;
            in_state_d = CAPTURE;
          end else begin
            fir_data_in_d = rx_byte;
            raw_sel_d     = 1'b0;
            in_state_d    = FEED;
          end
        end
      end
      FEED: begin
        wait_cnt_d = LAT;
        in_state_d = WAIT;
      end
      WAIT: begin
        // Leaving at a count of 1 makes WAIT last exactly FIR_LATENCY cycles.
        if (wait_cnt_q <= 4'd1) in_state_d = CAPTURE;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      CAPTURE: in_state_d = IN_IDLE;
      default: in_state_d = IN_IDLE;
    endcase
  end

  // Output FSM
  always_comb begin
    out_state_d = out_state_q;
    tx_byte_d   = tx_byte_q;
    case (out_state_q)
      TX_IDLE: begin
        if (count_q != '0) begin
          // Load the head now so that tx_byte is already valid when tx_dv rises.
          tx_byte_d   = mem_q[rd_ptr_q];
          out_state_d = TX_REQ;
        end
      end
      TX_REQ:  out_state_d = TX_WAIT;
      TX_WAIT: if (tx_done) out_state_d = TX_IDLE;
      default: out_state_d = TX_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and drop counter
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q    <= IN_IDLE;
      out_state_q   <= TX_IDLE;
      fir_data_in_q <= '0;
      raw_q         <= '0;
      raw_sel_q     <= 1'b0;
      wait_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drop_cnt_q    <= '0;
      tx_byte_q     <= '0;
    end else begin
      in_state_q    <= in_state_d;
      out_state_q   <= out_state_d;
      fir_data_in_q <= fir_data_in_d;
      raw_q         <= raw_d;
      raw_sel_q     <= raw_sel_d;
      wait_cnt_q    <= wait_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_cnt_q    <= drop_cnt_d;
      tx_byte_q     <= tx_byte_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= capture_val;
  end

  assign fir_data_in = fir_data_in_q;
  assign fir_strobe  = (in_state_q == FEED);
  assign tx_dv       = (out_state_q == TX_REQ);
  assign tx_byte     = tx_byte_q;
  assign fifo_count  = count_q;
  assign drop_cnt    = drop_cnt_q;
  assign busy        = (in_state_q != IN_IDLE) || (out_state_q != TX_IDLE) || (count_q != '0);

endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
Sequencer between the UART receiver, the FIR filter and the UART transmitter in the top-level loopback path. It captures each received byte, presents it to the FIR with a one-cycle strobe, waits a fixed pipeline latency, and queues the filtered result in a small FIFO. It then drains the FIFO into the transmitter using the DV/done handshake. It also provides a bypass mode (echo raw bytes) and saturating drop counters for lost bytes.

Parameters:
FIR_LATENCY, 4, cycles from fir_strobe until fir_data_out is valid (1..15)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_dv  in  1  one-cycle pulse: rx_byte valid
rx_byte  in  8  received byte
bypass  in  1  1 = skip FIR and queue raw rx_byte; sampled only in IN_IDLE
fir_data_in  out  8  byte presented to FIR
fir_strobe  out  1  one-cycle FIR input-valid
fir_data_out  in  8  FIR result
tx_dv  out  1  one-cycle transmit request
tx_byte  out  8  byte to transmit, held stable until the next tx_dv
tx_done  in  1  one-cycle pulse: transmitter finished
fifo_count  out  ADDR_W+1  current FIFO occupancy
drop_cnt  out  8  saturating count of discarded bytes
busy  out  1  1 when input FSM != IN_IDLE, or output FSM != TX_IDLE, or fifo_count != 0

Behaviour:
- Reset values:
  - fir_data_in = 0, fir_strobe = 0, tx_dv = 0, tx_byte = 0.
  - fifo_count = 0, drop_cnt = 0, busy = 0.
  - Both FSMs go to idle and the FIFO pointers are cleared.
  - Reset asserted mid-operation aborts everything in flight next edge; no partial transmit request is issued.
- Input FSM states: IN_IDLE, FEED, WAIT, CAPTURE.
  - IN_IDLE with rx_dv=1 and bypass=0: latch rx_byte into fir_data_in, go to FEED.
  - IN_IDLE with rx_dv=1 and bypass=1: latch rx_byte as the capture value, go to CAPTURE.
  - FEED: fir_strobe=1 for exactly this cycle. Load the wait counter with FIR_LATENCY, go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to CAPTURE (WAIT lasts exactly FIR_LATENCY cycles).
  - CAPTURE: push the capture value into the FIFO, go to IN_IDLE. The capture value is fir_data_out sampled this cycle for FIR-path bytes, or the latched raw byte for bypass bytes.
  - rx_dv=1 in any state other than IN_IDLE: the byte is dropped and drop_cnt increments.
  - Push with FIFO full: the byte is dropped and drop_cnt increments.
  - drop_cnt saturates at 255.
  - A drop in CAPTURE and a drop from rx_dv in the same cycle add +2 (still saturating).
- FIR-path timing: rx_dv sampled at cycle 0 → fir_strobe at cycle 1 → CAPTURE at cycle 2+FIR_LATENCY → fifo_count updated at cycle 3+FIR_LATENCY.
- Output FSM states: TX_IDLE, TX_REQ, TX_WAIT.
  - TX_IDLE with fifo_count != 0: go to TX_REQ.
  - TX_REQ: tx_dv=1 for this cycle only, tx_byte = FIFO head, pop the head. Go to TX_WAIT.
  - TX_WAIT: stay until tx_done=1, then go to TX_IDLE. Back-to-back bytes are therefore separated by at least 2 cycles after tx_done.
  - A tx_done arriving in TX_IDLE or TX_REQ is ignored.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: both are performed and fifo_count is unchanged.
  - Push when full: refused, even if a pop occurs in the same cycle.
  - Pop when empty: never occurs by construction.
- Widths: all data paths are 8-bit, with no arithmetic on data. fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then a single byte: rx_byte=0x5A, bypass=0, FIR model returns 0xA5 with L=4 → fir_strobe at cycle 1 with fir_data_in=0x5A; fifo_count=1 at cycle 7; tx_dv at cycle 8 with tx_byte=0xA5; exactly one tx_dv; drop_cnt=0.
- Bypass: bypass=1, rx_byte=0x33 → no fir_strobe; CAPTURE at cycle 1; tx_dv with tx_byte=0x33 at cycle 3.
- Busy drop: second rx_dv issued 2 cycles after the first (input FSM in WAIT) → only the first byte is transmitted; drop_cnt=1.
- Overflow and ordering: hold tx_done low; feed 6 bytes 0x01..0x06 with spacing ≥ L+3 in bypass → first byte popped (in TX_WAIT), FIFO fills with 0x02..0x05; 0x06 dropped; fifo_count=4; drop_cnt=1. Pulsing tx_done then releases 0x02, 0x03, 0x04, 0x05 in order.
- Simultaneous push/pop: CAPTURE in the same cycle as TX_REQ with fifo_count=2 → fifo_count stays 2; tx_byte equals the older entry.
- Reset mid-transfer: assert rst while in WAIT with fifo_count=2 → next cycle all outputs are 0 and busy=0; no tx_dv until a new rx_dv.
